// File: rtl/mem_requester_if.sv
// mem_requester_if: client request/response and two-phase ram bus bundle.
// master = requester side, slave = client + ram side.
interface mem_requester_if;
  logic        reqValidIn;
  logic        reqReadyOut;
  logic        reqRwIn;
  logic [31:0] reqAddrIn;
  logic [31:0] reqDataIn;
  logic        rspValidOut;
  logic [31:0] rspDataOut;
  logic        rspErrOut;
  logic [31:0] memAddrOut;
  logic [31:0] memDataOut;
  logic        memRwOut;
  logic        memTriggerOut;
  logic [31:0] memDataIn;
  logic        memReadyIn;

  modport master (
    input  reqValidIn, reqRwIn, reqAddrIn, reqDataIn,
    input  memDataIn, memReadyIn,
    output reqReadyOut, rspValidOut, rspDataOut, rspErrOut,
    output memAddrOut, memDataOut, memRwOut, memTriggerOut
  );

  modport slave (
    output reqValidIn, reqRwIn, reqAddrIn, reqDataIn,
    output memDataIn, memReadyIn,
    input  reqReadyOut, rspValidOut, rspDataOut, rspErrOut,
    input  memAddrOut, memDataOut, memRwOut, memTriggerOut
  );
endinterface

// File: rtl/mem_requester.sv
// mem_requester: single-outstanding client-to-ram requester, two-phase bus.
// Ports: clkIn, rstIn (sync, active-high), bus (mem_requester_if.master).
// MEM_REQUESTER_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES with rspErrOut.
module mem_requester #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clkIn,
  input  logic            rstIn,
  mem_requester_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic        trig_q, trig_d;
  logic        base_q, base_d;
  logic        sync1_q, sync2_q;

`ifdef MEM_REQUESTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign bus.rspErrOut = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign bus.rspErrOut = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    trig_d  = trig_q;
    base_d  = base_q;
`ifdef MEM_REQUESTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.reqValidIn) begin
          rw_d    = bus.reqRwIn;
          addr_d  = bus.reqAddrIn;
          wdata_d = bus.reqDataIn;
          ready_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // the ack is a level change relative to where the line sits now
        trig_d  = ~trig_q;
        base_d  = sync2_q;
        state_d = WAIT;
`ifdef MEM_REQUESTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (sync2_q != base_q) begin
          data_d  = rw_q ? 32'd0 : bus.memDataIn;
          valid_d = 1'b1;
          state_d = RESP;
`ifdef MEM_REQUESTER_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == LAST) begin
          data_d  = 32'd0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      trig_q  <= 1'b0;
      base_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
`ifdef MEM_REQUESTER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      trig_q  <= trig_d;
      base_q  <= base_d;
      sync1_q <= bus.memReadyIn;
      sync2_q <= sync1_q;
`ifdef MEM_REQUESTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.reqReadyOut   = ready_q;
  assign bus.rspValidOut   = valid_q;
  assign bus.rspDataOut    = data_q;
  assign bus.memAddrOut    = addr_q;
  assign bus.memDataOut    = wdata_q;
  assign bus.memRwOut      = rw_q;
  assign bus.memTriggerOut = trig_q;

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed bench for mem_requester with a
// two-phase ram model (ack follows trigger three cycles later).
module tb_mem_requester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_requester_if bus();

  mem_requester #(.TIMEOUT_CYCLES(8)) dut (
    .clkIn(clk),
    .rstIn(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [16] = '{
    32'h01, 32'h11, 32'h21, 32'h31, 32'h41, 32'h51, 32'h61, 32'h71,
    32'h81, 32'h91, 32'ha1, 32'hb1, 32'hc1, 32'hd1, 32'he1, 32'hf1
  };
  logic [2:0]  tpipe   = 3'b000;
  logic        ready_r = 1'b0;
  logic [31:0] rdata   = 32'd0;
  logic        spur    = 1'b0;
  logic        ram_en  = 1'b0;

  assign bus.memReadyIn = ready_r;
  assign bus.memDataIn  = rdata;

  always @(posedge clk) begin
    tpipe <= {tpipe[1:0], bus.memTriggerOut};
    if (ram_en && ((tpipe[2] ^ spur) !== ready_r)) begin
      ready_r <= tpipe[2] ^ spur;
      if (bus.memRwOut)
        mem[bus.memAddrOut[3:0]] <= bus.memDataOut;
      else
        rdata <= mem[bus.memAddrOut[3:0]];
    end
  end

  int   cyc = 0, hs_cnt = 0, tog_cnt = 0, rsp_cnt = 0;
  int   hs_cyc = 0, rsp_cyc = 0;
  logic trig_prev = 1'b0;
  logic [31:0] rsp_log [$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.reqValidIn && bus.reqReadyOut) begin
      hs_cnt++;
      hs_cyc = cyc;
    end
    if (bus.memTriggerOut !== trig_prev) tog_cnt++;
    trig_prev = bus.memTriggerOut;
    if (bus.rspValidOut === 1'b1) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_log.push_back(bus.rspDataOut);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic rw, input logic [31:0] a,
                        input logic [31:0] d);
    int h0;
    h0 = hs_cnt;
    @(negedge clk);
    bus.reqValidIn = 1'b1;
    bus.reqRwIn    = rw;
    bus.reqAddrIn  = a;
    bus.reqDataIn  = d;
    for (int n = 0; n < 60 && hs_cnt == h0; n++) @(negedge clk);
    bus.reqValidIn = 1'b0;
    check("handshake", 32'(hs_cnt - h0), 32'd1);
  endtask

  task automatic wait_rsp(input int r0, input string tag);
    for (int n = 0; n < 60 && rsp_cnt == r0; n++) @(negedge clk);
    check(tag, 32'(rsp_cnt - r0), 32'd1);
  endtask

  int r0, t0, h0;
  logic [31:0] a;

  initial begin
    bus.reqValidIn = 1'b0;
    bus.reqRwIn    = 1'b0;
    bus.reqAddrIn  = 32'd0;
    bus.reqDataIn  = 32'd0;

    // reset state
    rst = 1'b1;
    tick(3);
    check("rst_valid", 32'(bus.rspValidOut), 32'd0);
    check("rst_data", bus.rspDataOut, 32'd0);
    check("rst_err", 32'(bus.rspErrOut), 32'd0);
    check("rst_trig", 32'(bus.memTriggerOut), 32'd0);
    check("rst_rw", 32'(bus.memRwOut), 32'd0);
    check("rst_addr", bus.memAddrOut, 32'd0);
    check("rst_wdata", bus.memDataOut, 32'd0);
    rst = 1'b0;
    tick(1);
    check("rst_ready", 32'(bus.reqReadyOut), 32'd1);
    ram_en = 1'b1;
    tick(6);

    // write 31 to address 2
    r0 = rsp_cnt;
    t0 = tog_cnt;
    do_req(1'b1, 32'd2, 32'd31);
    check("wr_busy", 32'(bus.reqReadyOut), 32'd0);
    wait_rsp(r0, "wr_rsp");
    tick(2);
    check("wr_pulses", 32'(rsp_cnt - r0), 32'd1);
    check("wr_rdata", bus.rspDataOut, 32'd0);
    check("wr_err", 32'(bus.rspErrOut), 32'd0);
    check("wr_trig", 32'(bus.memTriggerOut), 32'd1);
    check("wr_addr", bus.memAddrOut, 32'd2);
    check("wr_wdata", bus.memDataOut, 32'd31);
    check("wr_rw", 32'(bus.memRwOut), 32'd1);
    check("wr_toggles", 32'(tog_cnt - t0), 32'd1);
    check("wr_ram", mem[2], 32'd31);

    // read back address 2
    r0 = rsp_cnt;
    do_req(1'b0, 32'd2, 32'd0);
    wait_rsp(r0, "rd_rsp");
    tick(2);
    check("rd_trig", 32'(bus.memTriggerOut), 32'd0);
    check("rd_data", bus.rspDataOut, 32'd31);
    check("rd_err", 32'(bus.rspErrOut), 32'd0);
    check("rd_lat_ge5", 32'(rsp_cyc - hs_cyc >= 5), 32'd1);

    // back-to-back reads of 5, 6, 7 with valid held
    r0 = rsp_cnt;
    t0 = tog_cnt;
    @(negedge clk);
    bus.reqValidIn = 1'b1;
    bus.reqRwIn    = 1'b0;
    bus.reqAddrIn  = 32'd5;
    for (int k = 0; k < 3; k++) begin
      h0 = hs_cnt;
      for (int n = 0; n < 60 && hs_cnt == h0; n++) @(negedge clk);
      check("b2b_hs", 32'(hs_cnt - h0), 32'd1);
      check("b2b_busy", 32'(bus.reqReadyOut), 32'd0);
      a = 32'd6 + 32'(k);
      bus.reqAddrIn = a;
      if (k == 2) bus.reqValidIn = 1'b0;
    end
    for (int n = 0; n < 80 && rsp_cnt < r0 + 3; n++) @(negedge clk);
    tick(3);
    check("b2b_pulses", 32'(rsp_cnt - r0), 32'd3);
    check("b2b_toggles", 32'(tog_cnt - t0), 32'd3);
    if (rsp_log.size() >= 3) begin
      check("b2b_d0", rsp_log[rsp_log.size()-3], 32'h51);
      check("b2b_d1", rsp_log[rsp_log.size()-2], 32'h61);
      check("b2b_d2", rsp_log[rsp_log.size()-1], 32'h71);
    end

    // spurious ack while idle, then a genuine read of address 4
    r0 = rsp_cnt;
    spur = 1'b1;
    tick(10);
    check("spur_none", 32'(rsp_cnt - r0), 32'd0);
    check("spur_ready", 32'(bus.reqReadyOut), 32'd1);
    do_req(1'b0, 32'd4, 32'd0);
    wait_rsp(r0, "spur_rsp");
    tick(2);
    check("spur_data", bus.rspDataOut, 32'h41);
    check("spur_lat_ge5", 32'(rsp_cyc - hs_cyc >= 5), 32'd1);

    // reset while waiting; the late ack must be dropped
    ram_en = 1'b0;
    r0 = rsp_cnt;
    do_req(1'b0, 32'd6, 32'd0);
    tick(5);
    check("rw_busy", 32'(bus.reqReadyOut), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    ram_en = 1'b1;
    tick(12);
    check("rw_none", 32'(rsp_cnt - r0), 32'd0);
    check("rw_trig", 32'(bus.memTriggerOut), 32'd0);
    check("rw_ready", 32'(bus.reqReadyOut), 32'd1);
    tick(4);
    r0 = rsp_cnt;
    do_req(1'b0, 32'd2, 32'd0);
    wait_rsp(r0, "rw_next_rsp");
    tick(1);
    check("rw_next_data", bus.rspDataOut, 32'd31);

    // no ack at all
    ram_en = 1'b0;
    r0 = rsp_cnt;
    do_req(1'b0, 32'd3, 32'd0);
`ifdef MEM_REQUESTER_TIMEOUT_EN
    wait_rsp(r0, "to_rsp");
    tick(1);
    check("to_err", 32'(bus.rspErrOut), 32'd1);
    check("to_data", bus.rspDataOut, 32'd0);
    check("to_lat", 32'(rsp_cyc - hs_cyc), 32'd10);
    ram_en = 1'b1;
    tick(12);
    check("to_late_ack", 32'(rsp_cnt - r0), 32'd1);
`else
    tick(1000);
    check("noto_none", 32'(rsp_cnt - r0), 32'd0);
    check("noto_busy", 32'(bus.reqReadyOut), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    ram_en = 1'b1;
    tick(1);
    check("noto_ready", 32'(bus.reqReadyOut), 32'd1);
    check("noto_err", 32'(bus.rspErrOut), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning WAIT-state cycles before abort (used only with MEM_REQUESTER_TIMEOUT_EN).
REQ-002 SHALL have port clkIn  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstIn  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port reqValidIn  input  1  client request valid.
REQ-005 SHALL have port reqReadyOut  output  1  requester can accept a request.
REQ-006 SHALL have port reqRwIn  input  1  1 = write, 0 = read.
REQ-007 SHALL have port reqAddrIn  input  32  request address.
REQ-008 SHALL have port reqDataIn  input  32  write data.
REQ-009 SHALL have port rspValidOut  output  1  one-cycle response pulse.
REQ-010 SHALL have port rspDataOut  output  32  read data; 0 for writes and errors.
REQ-011 SHALL have port rspErrOut  output  1  timeout flag, qualified by rspValidOut.
REQ-012 SHALL have port memAddrOut  output  32  address to ram.
REQ-013 SHALL have port memDataOut  output  32  write data to ram.
REQ-014 SHALL have port memRwOut  output  1  rw to ram.
REQ-015 SHALL have port memTriggerOut  output  1  two-phase request; each toggle = one transaction.
REQ-016 SHALL have port memDataIn  input  32  read data from ram.
REQ-017 SHALL have port memReadyIn  input  1  two-phase acknowledge from ram, asynchronous to clkIn.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-019 SHALL drive reqReadyOut=1 only in IDLE; handshake occurs when reqValidIn&reqReadyOut at a rising edge.
REQ-020 SHALL on handshake latch reqRwIn/reqAddrIn/reqDataIn into memRwOut/memAddrOut/memDataOut and go IDLE->ISSUE.
REQ-021 SHALL in ISSUE toggle memTriggerOut, record the current synchronized ack level as baseline, and go to WAIT (toggle visible 2 cycles after handshake).
REQ-022 SHALL hold memAddrOut/memDataOut/memRwOut stable from ISSUE until leaving WAIT.
REQ-023 SHALL pass memReadyIn through a 2-flop synchronizer; ack = synchronized level differs from baseline while in WAIT.
REQ-024 SHALL ignore memReadyIn transitions outside WAIT.
REQ-025 SHALL on ack capture memDataIn (read) or 0 (write) into rspDataOut and go WAIT->RESP.
REQ-026 SHALL in RESP assert rspValidOut for exactly one cycle, then return to IDLE; no response backpressure.
REQ-027 SHALL hold rspDataOut/rspErrOut until the next RESP; rspValidOut=0 outside RESP.
REQ-028 SHALL give minimum latency handshake->rspValidOut of 5 cycles (ISSUE, 2 sync, WAIT detect, RESP) with memReadyIn toggling immediately.
REQ-029 SHALL treat a reqValidIn held through a busy period as pending; it is accepted on the first IDLE cycle.

Reset
REQ-030 SHALL on rstIn=1 force state IDLE, reqReadyOut=1 after release, rspValidOut=0, rspDataOut=0, rspErrOut=0, memTriggerOut=0, memRwOut=0, memAddrOut=0, memDataOut=0, synchronizer flops 0, timeout counter 0.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation, with no response pulse; a late ack is ignored (REQ-024).

Configuration
REQ-032 SHALL, with MEM_REQUESTER_TIMEOUT_EN defined, count WAIT cycles and at TIMEOUT_CYCLES go to RESP with rspErrOut=1, rspDataOut=0; counter cleared on entry to WAIT.
REQ-033 SHALL, without MEM_REQUESTER_TIMEOUT_EN, wait indefinitely in WAIT and tie rspErrOut to 0.

Verification
REQ-034 Write: req rw=1 addr=2 data=31; ram model toggles memReadyIn 3 cycles after memTriggerOut -> memTriggerOut 0->1, memAddrOut=2, memDataOut=31, one rspValidOut pulse, rspDataOut=0, rspErrOut=0.
REQ-035 Read-back: req rw=0 addr=2; model returns 31 -> memTriggerOut 1->0, rspDataOut=31, latency >=5 cycles.
REQ-036 Back-to-back: reqValidIn held for 3 requests -> reqReadyOut low while busy, exactly 3 trigger toggles and 3 response pulses, in order.
REQ-037 Spurious ack: toggle memReadyIn while IDLE, then issue read -> no response from spurious edge; response only after genuine ack.
REQ-038 Reset in WAIT: assert rstIn for 1 cycle, then ack arrives -> no rspValidOut, memTriggerOut=0, next request completes normally.
REQ-039 Timeout (MEM_REQUESTER_TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack -> rspValidOut with rspErrOut=1, rspDataOut=0 after 8 WAIT cycles; without macro, no response after 1000 cycles.
